inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage for the single-issue MIPS core; the initiator side of the instruction ROM.
- Drives the word-aligned fetch address to the ROM and captures the combinationally returned instruction.
- Presents it to decode through an IF/ID register with a valid/ready handshake.
- Accepts redirects (branch/jump) that flush the slot, and a halt that stops new fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- PC_STEP, 4, byte increment per sequential fetch

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rom_pc  out  32  fetch address to instruction ROM; equals pc_reg combinationally
- rom_inst  in  32  instruction returned combinationally for rom_pc
- id_valid  out  1  IF/ID slot holds a valid instruction
- id_ready  in  1  decode accepts the slot this cycle
- id_inst  out  32  fetched instruction
- id_pc  out  32  address of id_inst
- id_pc_plus4  out  32  id_pc + PC_STEP, for branch/link arithmetic
- redirect_valid  in  1  one-cycle request to change fetch address
- redirect_target  in  32  new fetch address
- halt  in  1  level; suppresses new fetches while high
- misalign_err  out  1  one-cycle pulse: redirect_target[1:0] != 0
- fetch_count  out  32  number of instructions loaded into the slot

Behaviour:
- Reset (rst_n low, asynchronous): state=S_BOOT, pc_reg=RESET_PC, id_valid=0, id_inst=0, id_pc=0, id_pc_plus4=0, misalign_err=0, fetch_count=0.
- FSM:
  - S_BOOT: exactly one cycle after reset release; no load; goes to S_FETCH. A redirect in S_BOOT is applied to pc_reg; state still goes to S_FETCH.
  - S_FETCH: normal operation.
  - S_HALT: entered from S_FETCH when halt=1 at a clock edge with no redirect; returns to S_FETCH on the first edge with halt=0.
- load condition = (state==S_FETCH) && !halt && !redirect_valid && (!id_valid || id_ready).
- On load:
  - id_inst<=rom_inst, id_pc<=pc_reg, id_pc_plus4<=pc_reg+PC_STEP, id_valid<=1.
  - pc_reg<=pc_reg+PC_STEP; fetch_count++.
  - Latency: an instruction appears on id_* one cycle after its address is on rom_pc.
- Consume without load (id_valid && id_ready, no load): id_valid<=0. This applies in S_HALT.
- Stall (id_valid && !id_ready, no redirect): id_*, pc_reg and fetch_count all hold.
- Redirect (any state, highest priority):
  - pc_reg<={redirect_target[31:2],2'b00}; id_valid<=0 (flush, regardless of id_ready); no load that cycle.
  - misalign_err<=(redirect_target[1:0]!=0) for one cycle; otherwise 0.
  - Redirect during halt updates pc_reg and flushes; state stays S_HALT.
- Halt: no loads. A valid slot is kept until consumed. pc_reg holds.
- Arithmetic:
  - pc_reg+PC_STEP is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - fetch_count wraps modulo 2^32.
- id_inst/id_pc are never modified while id_valid=1 and id_ready=0.
- Reset mid-operation clears the slot immediately (asynchronous). No instruction is presented until two edges after rst_n rises.

Test Plan:
- Reset release, id_ready=1, ROM word1=0x00201020:
  - Cycle 1 (S_BOOT): id_valid=0.
  - Next edges: id_pc=0x0 then 0x4 with id_inst=0x00201020, id_pc_plus4=0x8.
  - fetch_count increments each cycle.
- Backpressure: id_ready=0 for 3 cycles while id_pc=0x8:
  - id_pc/id_inst hold, rom_pc stays 0xC, fetch_count frozen.
  - id_ready=1 -> next id_pc=0xC.
- Redirect while stalled (id_valid=1, id_ready=0), redirect_target=0x20:
  - Next cycle id_valid=0, rom_pc=0x20.
  - Following cycle id_pc=0x20, misalign_err never pulses.
- Misaligned redirect_target=0x0000_0036:
  - rom_pc=0x34, misalign_err=1 for exactly one cycle.
  - Next id_pc=0x34.
- Halt:
  - Assert halt with a valid slot, id_ready=1: slot consumed (id_valid=0), no further loads, rom_pc constant for 5 cycles.
  - Deassert halt: fetch resumes at the held address.
- Wrap and async reset:
  - redirect_target=0xFFFF_FFFC -> id_pc=0xFFFF_FFFC, id_pc_plus4=0x0, next id_pc=0x0.
  - Pull rst_n low mid-cycle -> id_valid=0, rom_pc=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: drives the ROM address, captures the returned word
// into a single IF/ID slot, and handles redirects, halt and stalls from decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_pc,
    input  logic [31:0] rom_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_reg;
    logic [31:0] pc_seq;
    logic [31:0] redirect_pc;
    logic        load;
    logic        consume;

    // IF/ID handshake: the slot transfers to decode on every clock edge where
    // id_valid and id_ready are both high. While id_valid=1 and id_ready=0 the
    // id_* fields hold. A redirect drops the slot without a transfer.
    assign consume     = id_valid && id_ready;
    assign load        = (state == S_FETCH) && !halt && !redirect_valid
                         && (!id_valid || id_ready);
    assign pc_seq      = pc_reg + PC_STEP;
    assign redirect_pc = {redirect_target[31:2], 2'b00};
    assign rom_pc      = pc_reg;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect never moves the FSM into or out of halt; only halt's level does.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (halt && !redirect_valid) state_nxt = S_HALT;
            S_HALT:  if (!halt) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= RESET_PC;
            id_valid    <= 1'b0;
            id_inst     <= 32'd0;
            id_pc       <= 32'd0;
            id_pc_plus4 <= 32'd0;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            pc_reg   <= redirect_pc;
            id_valid <= 1'b0;
        end else if (load) begin
            pc_reg      <= pc_seq;
            id_valid    <= 1'b1;
            id_inst     <= rom_inst;
            id_pc       <= pc_reg;
            id_pc_plus4 <= pc_seq;
            fetch_count <= fetch_count + 32'd1;
        end else if (consume) begin
            id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed walk through the fetch scenarios plus
// randomized traffic, compared every cycle against a cycle-level reference model.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_pc;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // Model of the fetch stage in terms of the observable rules
    bit          m_boot;
    bit          m_halted;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    bit          m_mis;
    logic [31:0] m_cnt;
    logic [31:0] exp_q[$];

    inst_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_pc          (rom_pc),
        .rom_inst        (rom_inst),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count),
        .dbg_state       (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h0020_1020;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign rom_inst = rom_word(rom_pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot   = 1;
        m_halted = 0;
        m_pc     = 32'h0000_0000;
        m_valid  = 0;
        m_inst   = 0;
        m_ipc    = 0;
        m_mis    = 0;
        m_cnt    = 0;
        exp_q.delete();
    endtask

    // One rising edge worth of fetch-stage rules, given the inputs held across it
    task automatic model_step(input bit rdy, input bit rv, input logic [31:0] tgt, input bit h);
        bit fetching;
        fetching = !m_boot && !m_halted;
        m_mis = rv && (tgt % 4 != 0);
        if (rv) begin
            if (m_valid) void'(exp_q.pop_front());
            m_pc    = tgt - (tgt % 4);
            m_valid = 0;
        end else if (fetching && !h && (!m_valid || rdy)) begin
            if (m_valid) void'(exp_q.pop_front());
            m_inst  = rom_word(m_pc);
            m_ipc   = m_pc;
            m_pc    = m_pc + 4;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            exp_q.push_back(m_inst);
        end else if (m_valid && rdy) begin
            void'(exp_q.pop_front());
            m_valid = 0;
        end
        if (m_boot)        m_boot = 0;
        else if (m_halted) m_halted = h;
        else               m_halted = h && !rv;
    endtask

    task automatic compare_all();
        check("rom_pc", rom_pc, m_pc);
        check("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        check("fetch_count", fetch_count, m_cnt);
        if (m_valid) begin
            check("id_inst", id_inst, m_inst);
            check("id_pc", id_pc, m_ipc);
            check("id_pc_plus4", id_pc_plus4, m_ipc + 32'd4);
        end
    endtask

    // Driver: entered at a falling edge, leaves at the next falling edge
    task automatic tick(input bit rdy, input bit rv, input logic [31:0] tgt, input bit h);
        compare_all();
        id_ready        = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        halt            = h;
        if (m_valid && rdy && !rv) begin
            if (exp_q.size() > 0) check("accept_inst", id_inst, exp_q[0]);
            else check("accept_queue", 32'd0, 32'd1);
        end
        @(posedge clk);
        model_step(rdy, rv, tgt, h);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held_pc;
        rst_n = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        halt = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_rom_pc", rom_pc, 32'd0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        rst_n = 1'b1;

        // Boot cycle then sequential fetch
        tick(1, 0, 0, 0);
        check("boot_no_valid", {31'd0, id_valid}, 32'd0);
        tick(1, 0, 0, 0);
        check("first_pc", id_pc, 32'h0);
        tick(1, 0, 0, 0);
        check("second_pc", id_pc, 32'h4);
        check("second_inst", id_inst, 32'h0020_1020);
        check("second_plus4", id_pc_plus4, 32'h8);
        check("second_count", fetch_count, 32'd2);
        tick(1, 0, 0, 0);

        // Backpressure at id_pc=0x8
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            check("stall_pc", id_pc, 32'h8);
            check("stall_rom_pc", rom_pc, 32'hC);
            check("stall_count", fetch_count, 32'd3);
        end
        tick(1, 0, 0, 0);
        check("release_pc", id_pc, 32'hC);

        // Redirect while stalled
        tick(0, 1, 32'h20, 0);
        check("redir_flush", {31'd0, id_valid}, 32'd0);
        check("redir_rom_pc", rom_pc, 32'h20);
        tick(1, 0, 0, 0);
        check("redir_pc", id_pc, 32'h20);
        check("redir_no_mis", {31'd0, misalign_err}, 32'd0);

        // Misaligned redirect
        tick(1, 1, 32'h36, 0);
        check("mis_rom_pc", rom_pc, 32'h34);
        check("mis_pulse", {31'd0, misalign_err}, 32'd1);
        tick(1, 0, 0, 0);
        check("mis_clear", {31'd0, misalign_err}, 32'd0);
        check("mis_pc", id_pc, 32'h34);

        // Halt with a valid slot
        tick(1, 0, 0, 1);
        check("halt_consumed", {31'd0, id_valid}, 32'd0);
        held_pc = m_pc;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 1);
            check("halt_rom_pc", rom_pc, held_pc);
        end
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("resume_pc", id_pc, held_pc);

        // Wrap at the top of the address space
        tick(1, 1, 32'hFFFF_FFFC, 0);
        tick(1, 0, 0, 0);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4, 32'h0);
        tick(1, 0, 0, 0);
        check("wrap_next", id_pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom, $urandom_range(0, 6) == 0);
        end
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, id_valid}, 32'd0);
        check("async_rom_pc", rom_pc, 32'h0);
        check("async_count", fetch_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 0, 0);
        check("post_rst_boot", {31'd0, id_valid}, 32'd0);
        for (int i = 0; i < 200; i++) begin
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 12) == 0,
                 $urandom, $urandom_range(0, 8) == 0);
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
